// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared state encoding and default operand width for seq_mul
package seq_mul_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul_addrow.sv
// rtl/seq_mul_addrow.sv - one conditional-add row of the shift-add multiplier
module seq_mul_addrow #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - sequential shift-add multiplier, WIDTH cycles per product,
// signed mode via magnitude multiply and final conditional negate
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 iStart,
  input  logic                 iSigned,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2*WIDTH-1:0]   oResult
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH:0]     hi;
  logic               neg;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     addend, sum;
  logic               cout;
  logic [WIDTH-1:0]   lo_nxt;
  logic [2*WIDTH-1:0] prod;

  // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude
  assign a_neg = iSigned & iA[WIDTH-1];
  assign b_neg = iSigned & iB[WIDTH-1];
  assign mag_a = a_neg ? -iA : iA;
  assign mag_b = b_neg ? -iB : iB;

  assign addend = lo[0] ? {1'b0, mcand} : '0;

  seq_mul_addrow #(.N(WIDTH + 1)) u_addrow (
    .a    (hi),
    .b    (addend),
    .sum  (sum),
    .cout (cout)
  );

  // Product register is {hi, lo}; each step adds into hi then shifts right by one
  assign lo_nxt = {sum[0], lo[WIDTH-1:1]};
  assign prod   = {sum[WIDTH:1], lo_nxt};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iStart) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mcand   <= '0;
      lo      <= '0;
      hi      <= '0;
      neg     <= 1'b0;
      oResult <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (iStart) begin
            mcand <= mag_a;
            lo    <= mag_b;
            hi    <= '0;
            cnt   <= '0;
            neg   <= a_neg ^ b_neg;
          end
        end
        RUN: begin
          hi  <= {cout, sum[WIDTH:1]};
          lo  <= lo_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) oResult <= neg ? -prod : prod;
        end
        default: ;
      endcase
    end
  end

  assign oBusy = (state != IDLE);
  assign oDone = (state == DONE);

endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - directed self-checking bench for seq_mul at WIDTH=16 and WIDTH=4
module tb_seq_mul;

  logic        Clock;
  logic        Reset_n;

  logic        start16, sgn16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] res16;

  logic        start4, sgn4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  res4;

  int n_tests = 0;
  int n_fail  = 0;

  seq_mul #(.WIDTH(16)) dut16 (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .iStart  (start16),
    .iSigned (sgn16),
    .iA      (a16),
    .iB      (b16),
    .oBusy   (busy16),
    .oDone   (done16),
    .oResult (res16)
  );

  seq_mul #(.WIDTH(4)) dut4 (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .iStart  (start4),
    .iSigned (sgn4),
    .iA      (a4),
    .iB      (b4),
    .oBusy   (busy4),
    .oDone   (done4),
    .oResult (res4)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts one 16-bit product and watches a fixed 45-edge window.
  // lat = rising edges from the accept edge to the first edge that samples oDone high.
  // poke > 0 fires a stray start with other operands at that RUN edge count.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                       input int poke, output logic [31:0] res, output int lat,
                       output int ndone);
    int edges;
    logic d;
    lat   = -1;
    ndone = 0;
    res   = 'x;
    @(negedge Clock);
    a16 = a; b16 = b; sgn16 = sgn; start16 = 1'b1;
    @(posedge Clock);
    #1 start16 = 1'b0;
    edges = 0;
    while (edges < 45) begin
      @(negedge Clock);
      if (poke > 0 && edges == poke) begin
        start16 = 1'b1; a16 = 16'h0101; b16 = 16'h0202; sgn16 = ~sgn;
      end
      if (poke > 0 && edges == poke + 1) start16 = 1'b0;
      d = done16;
      if (d) begin
        ndone++;
        if (lat < 0) res = res16;
      end
      @(posedge Clock);
      edges++;
      if (d && lat < 0) lat = edges;
    end
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL run16_timeout: got no oDone within 45 edges, required one");
    end
  endtask

  typedef struct {
    string       tag;
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] r;
    int          lat, nd, edges;
    logic        d;

    vecs[0] = '{"u_3x5",        16'h0003, 16'h0005, 1'b0, 32'h0000000F};
    vecs[1] = '{"u_ffffxffff",  16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[2] = '{"s_m1xm1",      16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vecs[3] = '{"s_minxmin",    16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vecs[4] = '{"s_m3x5",       16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1};
    vecs[5] = '{"s_0xm5",       16'h0000, 16'hFFFB, 1'b1, 32'h00000000};
    vecs[6] = '{"s_m7x3",       16'hFFF9, 16'h0003, 1'b1, 32'hFFFFFFEB};
    vecs[7] = '{"u_8000x2",     16'h8000, 16'h0002, 1'b0, 32'h00010000};

    Reset_n = 1'b0;
    start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    start4  = 1'b0; sgn4  = 1'b0; a4  = '0; b4  = '0;
    repeat (2) @(negedge Clock);
    check_eq("rst_busy16", busy16, 1'b0);
    check_eq("rst_done16", done16, 1'b0);
    check_eq("rst_res16",  res16,  32'h0);
    check_eq("rst_busy4",  busy4,  1'b0);
    check_eq("rst_res4",   res4,   8'h0);
    Reset_n = 1'b1;

    foreach (vecs[i]) begin
      run16(vecs[i].a, vecs[i].b, vecs[i].sgn, 0, r, lat, nd);
      check_eq({vecs[i].tag, "_res"}, r, vecs[i].exp);
      check_eq({vecs[i].tag, "_lat"}, lat, 17);
      check_eq({vecs[i].tag, "_ndone"}, nd, 1);
    end
    check_eq("idle_hold_res", res16, 32'h00010000);
    check_eq("idle_busy", busy16, 1'b0);

    // stray start plus operand changes during RUN must not disturb the product
    run16(16'h0003, 16'h0005, 1'b0, 5, r, lat, nd);
    check_eq("poke_res", r, 32'h0000000F);
    check_eq("poke_ndone", nd, 1);
    check_eq("poke_lat", lat, 17);

    // reset in the middle of RUN
    @(negedge Clock);
    a16 = 16'h1234; b16 = 16'h0042; sgn16 = 1'b0; start16 = 1'b1;
    @(posedge Clock);
    #1 start16 = 1'b0;
    check_eq("mid_busy_before", busy16, 1'b1);
    repeat (8) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy16, 1'b0);
    check_eq("mid_rst_res",  res16,  32'h0);
    check_eq("mid_rst_done", done16, 1'b0);
    nd = 0;
    repeat (3) begin
      @(negedge Clock);
      if (done16) nd++;
    end
    Reset_n = 1'b1;
    repeat (20) begin
      @(negedge Clock);
      if (done16) nd++;
    end
    check_eq("mid_rst_no_done", nd, 0);
    run16(16'd7, 16'd9, 1'b0, 0, r, lat, nd);
    check_eq("after_rst_res", r, 32'd63);
    check_eq("after_rst_lat", lat, 17);

    // WIDTH=4: 15x15 then back-to-back 2x2 started in the cycle after DONE
    @(negedge Clock);
    a4 = 4'd15; b4 = 4'd15; sgn4 = 1'b0; start4 = 1'b1;
    @(posedge Clock);
    #1 start4 = 1'b0;
    edges = 0; lat = -1;
    while (edges < 20 && lat < 0) begin
      @(negedge Clock);
      d = done4;
      if (d) r = {24'h0, res4};
      @(posedge Clock);
      edges++;
      if (d) lat = edges;
    end
    check_eq("w4_15x15_res", r, 32'd225);
    check_eq("w4_15x15_lat", lat, 5);
    #1;
    a4 = 4'd2; b4 = 4'd2; start4 = 1'b1;
    @(negedge Clock);
    check_eq("w4_idle_busy", busy4, 1'b0);
    check_eq("w4_idle_hold", res4, 8'd225);
    @(posedge Clock);
    #1 start4 = 1'b0;
    check_eq("w4_b2b_accept", busy4, 1'b1);
    edges = 0; lat = -1;
    while (edges < 20 && lat < 0) begin
      @(negedge Clock);
      d = done4;
      if (d) r = {24'h0, res4};
      @(posedge Clock);
      edges++;
      if (d) lat = edges;
    end
    check_eq("w4_2x2_res", r, 32'd4);
    check_eq("w4_2x2_lat", lat, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mul.md
SEQ_MUL -- requirements
Module: seq_mul

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; legal range 4..32.
REQ-002 Port: Clock  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: Reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: iStart  input  1  request to begin a multiplication.
REQ-005 Port: iSigned  input  1  1 = two's-complement operands, 0 = unsigned; sampled with iStart.
REQ-006 Port: iA  input  WIDTH  multiplicand.
REQ-007 Port: iB  input  WIDTH  multiplier.
REQ-008 Port: oBusy  output  1  high while a multiplication is in progress (RUN or DONE).
REQ-009 Port: oDone  output  1  one-cycle pulse marking oResult valid and new.
REQ-010 Port: oResult  output  2*WIDTH  product; holds its value until the next oDone.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 In IDLE with iStart=1 at a rising edge, the block SHALL capture iA, iB and iSigned, clear the accumulator, load the cycle counter with 0 and enter RUN.
REQ-013 In IDLE with iStart=0, the block SHALL remain in IDLE and SHALL NOT change oResult.
REQ-014 RUN SHALL last exactly WIDTH cycles; each cycle SHALL add the shifted multiplicand magnitude to the accumulator when the current multiplier bit is 1, then shift, then increment the counter.
REQ-015 After the counter reaches WIDTH-1, the block SHALL enter DONE; DONE SHALL last one cycle with oDone=1, then return to IDLE.
REQ-016 oResult SHALL update on the edge that enters DONE; oDone SHALL be high in the cycle exactly WIDTH+1 rising edges after the accepting edge.
REQ-017 oBusy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-018 iStart asserted while oBusy=1 SHALL be ignored; it SHALL be neither queued nor allowed to corrupt captured operands.
REQ-019 Back-to-back operation: iStart=1 in the cycle after DONE SHALL be accepted, giving one result every WIDTH+2 cycles.
REQ-020 Unsigned mode: oResult SHALL be the exact 2*WIDTH-bit product of iA and iB.
REQ-021 Signed mode: operands SHALL be converted to magnitudes, multiplied unsigned, and the product negated (two's complement, 2*WIDTH bits) when the operand signs differ.
REQ-022 Signed magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1), held unsigned in WIDTH bits, with no overflow.
REQ-023 A zero operand SHALL still take the full WIDTH cycles; oResult SHALL be 0 and never -0 handling artefacts.
REQ-024 Input changes on iA, iB and iSigned during RUN SHALL have no effect on the result.

Reset
REQ-025 Reset_n=0 SHALL immediately force IDLE, oBusy=0, oDone=0, oResult=0, and clear the counter and accumulator.
REQ-026 Reset_n asserted mid-RUN SHALL abort the operation with no oDone pulse; the first iStart after release SHALL be accepted normally.
REQ-027 Reset release SHALL take effect at the first rising edge with Reset_n=1.

Structure
REQ-028 The FSM state encoding (IDLE, RUN, DONE) and the default WIDTH constant SHALL reside in shared package seq_mul_pkg.
REQ-029 The per-cycle conditional add SHALL be one sub-module, seq_mul_addrow: a WIDTH+1-bit adder with carry-out, instantiated once.
REQ-030 Counter width SHALL be $clog2(WIDTH)+1 bits; no combinational path SHALL exist from inputs to outputs.

Verification (WIDTH=16 unless noted)
REQ-031 Unsigned: iA=3, iB=5 -> oResult=0x0000000F, oDone 17 edges after accept.
REQ-032 Unsigned: iA=0xFFFF, iB=0xFFFF -> 0xFFFE0001. Signed: same operands (-1 x -1) -> 0x00000001.
REQ-033 Signed: iA=0x8000, iB=0x8000 -> 0x40000000; iA=0xFFFD (-3), iB=5 -> 0xFFFFFFF1.
REQ-034 iStart pulsed at RUN cycle 5 with different operands -> ignored; first result is unchanged and exactly one oDone pulse occurs.
REQ-035 Reset_n low at RUN cycle 8 -> oBusy=0, oResult=0, no oDone; next start 7x9 -> 63.
REQ-036 WIDTH=4: 15x15 unsigned -> 225, latency 5 edges; back-to-back 2x2 -> 4 accepted the cycle after DONE.
